mem_stage: RTL
==============

# mem_stage

Memory stage of the 5-stage RV32I pipeline, directly downstream of the execute-stage ALU. Registers the ALU result bundle and, for loads and stores, runs a request/grant/response transaction on the data-memory port, doing byte-lane alignment, store-data replication and load sign/zero extension. Presents a registered write-back bundle to the WB stage and stalls upstream while a memory access is outstanding.

## Interface
- TIMEOUT_CYCLES, 255: max cycles in any wait state before aborting with busErr (1..65535).
- clk  in  1  core clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- exValid  in  1  execute-stage bundle valid this cycle.
- aluResult  in  32  ALU result (`result` field): effective address for loads/stores, write-back data otherwise.
- rs2F  in  32  forwarded rs2 (store data).
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- memRead  in  1  load.
- memWrite  in  1  store (memRead && memWrite never both set).
- rd  in  5  destination register.
- regWrite  in  1  instruction writes rd.
- stall  out  1  stage busy; upstream must hold its bundle.
- dmemReq  out  1  memory request.
- dmemWe  out  1  write enable.
- dmemAddr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmemWdata  out  32  lane-replicated store data.
- dmemBe  out  4  byte enables.
- dmemGnt  in  1  request accepted this cycle.
- dmemRvalid  in  1  read data valid.
- dmemRdata  in  32  read data word.
- wbValid  out  1  write-back bundle valid (one-cycle pulse per instruction).
- wbData  out  32  write-back data.
- wbRd  out  5  destination register.
- wbRegWrite  out  1  write enable to register file (forced 0 on fault).
- misaligned  out  1  alignment fault for this bundle.
- busErr  out  1  memory timeout fault for this bundle.

## Operation
- States: IDLE, REQ, RESP. stall = (state != IDLE). Bundle accepted on any edge with exValid && state==IDLE.
- Non-memory accept: next cycle wbValid=1, wbData=aluResult, wbRd=rd, wbRegWrite=regWrite; stay IDLE.
- Misalignment: H/HU with addr[0]=1, W with addr[1:0]!=0. Treated as non-memory: no bus access, next cycle wbValid=1, misaligned=1, wbRegWrite=0, wbData=aluResult.
- Aligned load/store accept: latch addr, rd, funct3, store data; go REQ.
- REQ: dmemReq=1; dmemAddr/dmemWe/dmemWdata/dmemBe stable until grant. On dmemGnt: store -> IDLE with wbValid=1, wbRegWrite=0 next cycle; load -> RESP.
- RESP: on dmemRvalid, select lane by addr[1:0] (halfword by addr[1]), sign-extend (B, H) or zero-extend (BU, HU); next cycle wbValid=1, wbData=extended value, wbRegWrite=regWrite; go IDLE.
- Store lanes: SB Be=0001<<addr[1:0], Wdata={4{rs2F[7:0]}}; SH Be=0011<<addr[1:0], Wdata={2{rs2F[15:0]}}; SW Be=1111, Wdata=rs2F.
- Timeout: wait counter cleared on entering REQ and RESP, increments each wait cycle; reaching TIMEOUT_CYCLES without gnt/rvalid -> drop dmemReq, IDLE, next cycle wbValid=1, busErr=1, wbRegWrite=0.
- dmemRvalid outside RESP and dmemGnt outside REQ are ignored.

## Timing
- Reset (async, nReset=0): state IDLE, counter 0, all outputs 0 (stall, dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe, wbValid, wbData, wbRd, wbRegWrite, misaligned, busErr). Reset mid-transaction abandons it; no write-back issued.
- Latency: non-memory/misaligned 1 cycle. Store: accept edge E0, dmemReq from E0; gnt sampled at E1 -> wbValid after E1. Load with gnt at E1, rvalid at E2 -> wbValid after E2; stall high cycles E0..E2.
- Next bundle accepted earliest on the edge after return to IDLE (no overlap).
- Grant and rvalid in the same cycle in REQ: rvalid ignored; memory must return data in a later cycle.
- wbValid, misaligned, busErr are single-cycle pulses; wbData/wbRd hold until next write-back.

## Test plan
- ADD bundle aluResult=0x0000_1234, rd=5, regWrite=1 -> one cycle later wbValid=1, wbData=0x1234, wbRd=5, no dmemReq.
- SB addr=0x103, rs2F=0xAABBCCDD, gnt 2 cycles late -> dmemAddr=0x100, Be=1000, Wdata=0xDDDDDDDD held stable; wbValid with wbRegWrite=0 after grant.
- LB addr=0x202, rdata=0x0080_0000 -> wbData=0xFFFF_FF80; LBU same -> 0x0000_0080; LH addr=0x202, rdata=0x8001_0000 -> 0xFFFF_8001.
- LW addr=0x0000_0006 -> no dmemReq, wbValid=1, misaligned=1, wbRegWrite=0 next cycle.
- LW with no rvalid for TIMEOUT_CYCLES=4 -> dmemReq drops, busErr pulse, stall releases, next bundle accepted.
- nReset asserted in RESP -> all outputs 0 immediately, stall=0; late rvalid after release ignored, no wbValid.

Source files
------------

// File: rtl/mem_stage.sv
// RV32I memory stage: registers the ALU bundle, runs the data-memory
// request/grant/response handshake and produces the write-back bundle.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        exValid,
    input  logic [31:0] aluResult,
    input  logic [31:0] rs2F,
    input  logic [2:0]  funct3,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [4:0]  rd,
    input  logic        regWrite,
    output logic        stall,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWdata,
    output logic [3:0]  dmemBe,
    input  logic        dmemGnt,
    input  logic        dmemRvalid,
    input  logic [31:0] dmemRdata,
    output logic        wbValid,
    output logic [31:0] wbData,
    output logic [4:0]  wbRd,
    output logic        wbRegWrite,
    output logic        misaligned,
    output logic        busErr
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, cnt_nxt;

    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        we_q, rw_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;

    logic        latch_en, in_mis, wb_fire, wb_rw_nxt, mis_nxt, berr_nxt;
    logic [31:0] wb_data_nxt, wdata_in, lane, load_val;
    logic [4:0]  wb_rd_nxt;
    logic [3:0]  be_in;

    // Alignment check and store lane placement from the incoming bundle
    always_comb begin
        in_mis   = 1'b0;
        be_in    = 4'b1111;
        wdata_in = rs2F;
        case (funct3[1:0])
            2'b00: begin
                be_in    = 4'b0001 << aluResult[1:0];
                wdata_in = {4{rs2F[7:0]}};
            end
            2'b01: begin
                in_mis   = aluResult[0];
                be_in    = 4'b0011 << aluResult[1:0];
                wdata_in = {2{rs2F[15:0]}};
            end
            default: in_mis = |aluResult[1:0];
        endcase
    end

    // Halfword lanes are 2-byte aligned here, so a byte-granular shift covers both sizes
    always_comb begin
        lane = dmemRdata >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = wait_cnt;
        latch_en    = 1'b0;
        wb_fire     = 1'b0;
        wb_data_nxt = wbData;
        wb_rd_nxt   = wbRd;
        wb_rw_nxt   = 1'b0;
        mis_nxt     = 1'b0;
        berr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (exValid) begin
                    if ((memRead || memWrite) && !in_mis) begin
                        latch_en  = 1'b1;
                        state_nxt = REQ;
                        cnt_nxt   = '0;
                    end else begin
                        wb_fire     = 1'b1;
                        wb_data_nxt = aluResult;
                        wb_rd_nxt   = rd;
                        mis_nxt     = (memRead || memWrite) && in_mis;
                        wb_rw_nxt   = regWrite && !mis_nxt;
                    end
                end
            end
            REQ: begin
                if (dmemGnt) begin
                    if (we_q) begin
                        state_nxt   = IDLE;
                        wb_fire     = 1'b1;
                        wb_data_nxt = addr_q;
                        wb_rd_nxt   = rd_q;
                    end else begin
                        state_nxt = RESP;
                        cnt_nxt   = '0;
                    end
                end else if (wait_cnt == TO_LAST) begin
                    state_nxt   = IDLE;
                    wb_fire     = 1'b1;
                    berr_nxt    = 1'b1;
                    wb_data_nxt = addr_q;
                    wb_rd_nxt   = rd_q;
                end else begin
                    cnt_nxt = wait_cnt + 16'd1;
                end
            end
            RESP: begin
                if (dmemRvalid) begin
                    state_nxt   = IDLE;
                    wb_fire     = 1'b1;
                    wb_data_nxt = load_val;
                    wb_rd_nxt   = rd_q;
                    wb_rw_nxt   = rw_q;
                end else if (wait_cnt == TO_LAST) begin
                    state_nxt   = IDLE;
                    wb_fire     = 1'b1;
                    berr_nxt    = 1'b1;
                    wb_data_nxt = addr_q;
                    wb_rd_nxt   = rd_q;
                end else begin
                    cnt_nxt = wait_cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            rw_q       <= 1'b0;
            rd_q       <= '0;
            f3_q       <= '0;
            wbValid    <= 1'b0;
            wbData     <= '0;
            wbRd       <= '0;
            wbRegWrite <= 1'b0;
            misaligned <= 1'b0;
            busErr     <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= cnt_nxt;
            wbValid    <= wb_fire;
            wbData     <= wb_data_nxt;
            wbRd       <= wb_rd_nxt;
            wbRegWrite <= wb_rw_nxt;
            misaligned <= mis_nxt;
            busErr     <= berr_nxt;
            if (latch_en) begin
                addr_q  <= aluResult;
                wdata_q <= wdata_in;
                be_q    <= memWrite ? be_in : 4'b1111;
                we_q    <= memWrite;
                rw_q    <= regWrite;
                rd_q    <= rd;
                f3_q    <= funct3;
            end
        end
    end

    // Bus outputs are qualified by REQ so they read zero whenever no request is live
    always_comb begin
        stall     = (state != IDLE);
        dmemReq   = (state == REQ);
        dmemWe    = dmemReq && we_q;
        dmemAddr  = dmemReq ? {addr_q[31:2], 2'b00} : '0;
        dmemWdata = dmemWe ? wdata_q : '0;
        dmemBe    = dmemReq ? be_q : '0;
    end

endmodule
